lc3_ctrl_fsm: RTL and testbench

Parametrised next-generation LC3 multicycle sequencer. It walks the fetch/decode/execute/memory/writeback state graph, driven by the 6-bit decode control word. Unlike the first-generation controller, it does the following:
- waits on memory completion only in memory states
- drives its own memory request strobes
- detects memory timeouts and illegal state codes, entering a recoverable ERROR state
- counts retired instructions

It sits between Decode and the memory interface and replaces the first-generation controller.

---
 rtl/lc3_ctrl_pkg.sv | 47 ++++
 rtl/lc3_ctrl_fsm_wait_timer.sv | 27 ++
 rtl/lc3_ctrl_fsm.sv | 103 ++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC3 multicycle sequencer: state codes, control-word
// field positions, error codes and the memory-state predicate.
package lc3_ctrl_pkg;

  // state | meaning
  // 1  FETCH      instruction read, waits on complete
  // 2  DECODE     route on C_Control[5:4]
  // 3  EXECUTE    ALU operation
  // 4  CALC_PC    branch/jump target
  // 5  CALC_ADDR  effective address, route on memory op
  // 6  READ_MEM   data read, waits on complete
  // 7  IND_READ   pointer read for indirect modes
  // 8  WRITE_MEM  data write, waits on complete
  // 9  UPDATE_RF  register file writeback
  // 10 UPDATE_PC  PC update, instruction retires
  // 15 ERROR      timeout or illegal code, waits for err_clear
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXECUTE   = 4'd3,
    ST_CALC_PC   = 4'd4,
    ST_CALC_ADDR = 4'd5,
    ST_READ_MEM  = 4'd6,
    ST_IND_READ  = 4'd7,
    ST_WRITE_MEM = 4'd8,
    ST_UPDATE_RF = 4'd9,
    ST_UPDATE_PC = 4'd10,
    ST_ERROR     = 4'd15
  } state_t;

  localparam int C_ROUTE_HI = 5;
  localparam int C_ROUTE_LO = 4;
  localparam int C_TGT_WB   = 3;
  localparam int C_MEMOP_HI = 2;
  localparam int C_MEMOP_LO = 1;
  localparam int C_IND      = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_READ_MEM) ||
           (s == ST_IND_READ) || (s == ST_WRITE_MEM);
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_wait_timer.sv
// Memory wait counter: clears on request, counts waiting cycles and flags the
// last allowed waiting cycle. Used only when LC3_CTRL_TIMEOUT_EN is defined.
module lc3_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] wait_cnt;

  assign expired = (wait_cnt == LAST);

  // Saturate at LAST; the FSM leaves the memory state on that cycle anyway.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (inc && !expired) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end
endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC3 multicycle sequencer with memory strobes, retire counter and ERROR state.
// Define LC3_CTRL_TIMEOUT_EN to enable the memory-wait timeout.
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RETIRE_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          C_Control,
  input  logic                complete,
  input  logic                err_clear,
  output logic [3:0]          state,
  output logic                mem_req,
  output logic                mem_we,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [RETIRE_W-1:0] retire_cnt
);
  state_t state_q;
  logic   in_mem;
  logic   timeout;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lc3_ctrl_fsm: TIMEOUT_CYCLES out of range 2..65535");
  end

  assign in_mem  = is_mem_state(state_q);
  assign state   = state_q;
  assign mem_req = in_mem;
  assign mem_we  = (state_q == ST_WRITE_MEM);
  assign err     = (state_q == ST_ERROR);

`ifdef LC3_CTRL_TIMEOUT_EN
  // Held clear outside memory states, so every entry starts from zero.
  lc3_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_mem || complete),
    .inc     (in_mem && !complete),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      err_code   <= ERR_NONE;
      retire_cnt <= '0;
    end else begin
      case (state_q)
        ST_FETCH, ST_READ_MEM, ST_IND_READ, ST_WRITE_MEM: begin
          if (complete) begin
            case (state_q)
              ST_FETCH:    state_q <= ST_DECODE;
              ST_READ_MEM: state_q <= ST_UPDATE_RF;
              ST_IND_READ: state_q <= C_Control[C_IND] ? ST_READ_MEM : ST_WRITE_MEM;
              default:     state_q <= ST_UPDATE_PC;
            endcase
          end else if (timeout) begin
            state_q  <= ST_ERROR;
            err_code <= ERR_TIMEOUT;
          end
        end
        ST_DECODE: begin
          case (C_Control[C_ROUTE_HI:C_ROUTE_LO])
            2'b00:   state_q <= ST_EXECUTE;
            2'b01:   state_q <= ST_CALC_PC;
            default: state_q <= ST_CALC_ADDR;
          endcase
        end
        ST_EXECUTE: state_q <= ST_UPDATE_RF;
        ST_CALC_PC: state_q <= C_Control[C_TGT_WB] ? ST_UPDATE_RF : ST_UPDATE_PC;
        ST_CALC_ADDR: begin
          case (C_Control[C_MEMOP_HI:C_MEMOP_LO])
            2'b00:   state_q <= ST_IND_READ;
            2'b01:   state_q <= ST_READ_MEM;
            2'b10:   state_q <= ST_WRITE_MEM;
            default: state_q <= ST_UPDATE_RF;
          endcase
        end
        ST_UPDATE_RF: state_q <= ST_UPDATE_PC;
        ST_UPDATE_PC: begin
          state_q    <= ST_FETCH;
          retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
        ST_ERROR: begin
          if (err_clear) begin
            state_q  <= ST_FETCH;
            err_code <= ERR_NONE;
          end
        end
        default: begin
          state_q  <= ST_ERROR;
          err_code <= ERR_ILLEGAL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm with TIMEOUT_CYCLES=4, RETIRE_W=2.
module tb_lc3_ctrl_fsm;
  import lc3_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] C_Control;
  logic       complete;
  logic       err_clear;
  logic [3:0] state;
  logic       mem_req;
  logic       mem_we;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef LC3_CTRL_TIMEOUT_EN
  localparam logic [1:0] RET_AFTER_4TH = 2'd0;
  localparam logic [1:0] RET_FINAL     = 2'd1;
`else
  localparam logic [1:0] RET_AFTER_4TH = 2'd1;
  localparam logic [1:0] RET_FINAL     = 2'd2;
`endif

  lc3_ctrl_fsm #(.TIMEOUT_CYCLES(4), .RETIRE_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .C_Control  (C_Control),
    .complete   (complete),
    .err_clear  (err_clear),
    .state      (state),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .err        (err),
    .err_code   (err_code),
    .retire_cnt (retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic go(input string tag, input logic [3:0] st);
    step();
    check(tag, 16'(state), 16'(st));
  endtask

  // Hold in memory state st for n cycles with complete low, then raise complete.
  task automatic mem_wait(input string tag, input logic [3:0] st, input int n);
    complete = 1'b0;
    repeat (n) begin
      step();
      check({tag, "_hold"}, 16'(state), 16'(st));
      check({tag, "_req"}, 16'(mem_req), 16'd1);
      check({tag, "_we"}, 16'(mem_we), (st == 4'd8) ? 16'd1 : 16'd0);
    end
    complete = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; C_Control = 6'b0; complete = 1'b0; err_clear = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_state", 16'(state), 16'd1);
    check("rst_retire", 16'(retire_cnt), 16'd0);
    check("rst_err_code", 16'(err_code), 16'd0);
    check("rst_mem_req", 16'(mem_req), 16'd1);
    check("rst_mem_we", 16'(mem_we), 16'd0);
    check("rst_err", 16'(err), 16'd0);

    // ADD path
    C_Control = 6'b000000; complete = 1'b1;
    go("add_decode", 4'd2);
    check("add_decode_req", 16'(mem_req), 16'd0);
    go("add_execute", 4'd3);
    check("add_execute_req", 16'(mem_req), 16'd0);
    go("add_update_rf", 4'd9);
    go("add_update_pc", 4'd10);
    check("add_update_pc_req", 16'(mem_req), 16'd0);
    go("add_fetch", 4'd1);
    check("add_retire", 16'(retire_cnt), 16'd1);

    // LDI path, 3 waiting cycles in each memory state
    C_Control = 6'b100001;
    mem_wait("ldi_fetch", 4'd1, 3);
    go("ldi_decode", 4'd2);
    go("ldi_calc_addr", 4'd5);
    check("ldi_calc_addr_we", 16'(mem_we), 16'd0);
    go("ldi_ind_read", 4'd7);
    mem_wait("ldi_ind", 4'd7, 3);
    go("ldi_read_mem", 4'd6);
    mem_wait("ldi_rd", 4'd6, 3);
    go("ldi_update_rf", 4'd9);
    check("ldi_update_rf_we", 16'(mem_we), 16'd0);
    go("ldi_update_pc", 4'd10);
    go("ldi_fetch", 4'd1);
    check("ldi_retire", 16'(retire_cnt), 16'd2);

    // ST path
    C_Control = 6'b100100; complete = 1'b1;
    go("st_decode", 4'd2);
    check("st_decode_we", 16'(mem_we), 16'd0);
    go("st_calc_addr", 4'd5);
    check("st_calc_addr_we", 16'(mem_we), 16'd0);
    go("st_write_mem", 4'd8);
    check("st_write_mem_we", 16'(mem_we), 16'd1);
    check("st_write_mem_req", 16'(mem_req), 16'd1);
    go("st_update_pc", 4'd10);
    check("st_update_pc_we", 16'(mem_we), 16'd0);
    go("st_fetch", 4'd1);
    check("st_retire", 16'(retire_cnt), 16'd3);

    // READ_MEM never completing
    C_Control = 6'b100010; complete = 1'b1;
    go("to_decode", 4'd2);
    go("to_calc_addr", 4'd5);
    go("to_read_mem", 4'd6);
    complete = 1'b0;
`ifdef LC3_CTRL_TIMEOUT_EN
    go("to_wait1", 4'd6);
    go("to_wait2", 4'd6);
    go("to_wait3", 4'd6);
    go("to_error", 4'd15);
    check("to_err_code", 16'(err_code), 16'd2);
    check("to_err", 16'(err), 16'd1);
    check("to_err_req", 16'(mem_req), 16'd0);
    go("err_hold", 4'd15);
    err_clear = 1'b1;
    go("err_clear_fetch", 4'd1);
    err_clear = 1'b0;
    check("err_clear_code", 16'(err_code), 16'd0);
    check("err_clear_err", 16'(err), 16'd0);
    check("err_clear_retire", 16'(retire_cnt), 16'd3);
`else
    repeat (8) go("nto_hold", 4'd6);
    check("nto_err_code", 16'(err_code), 16'd0);
    complete = 1'b1;
    go("nto_update_rf", 4'd9);
    go("nto_update_pc", 4'd10);
    go("nto_fetch", 4'd1);
    check("nto_retire", 16'(retire_cnt), 16'd0);
`endif

    // complete arriving on the 4th waiting cycle wins over the timeout
    complete = 1'b1;
    go("c4_decode", 4'd2);
    go("c4_calc_addr", 4'd5);
    go("c4_read_mem", 4'd6);
    mem_wait("c4", 4'd6, 3);
    go("c4_update_rf", 4'd9);
    check("c4_err_code", 16'(err_code), 16'd0);
    go("c4_update_pc", 4'd10);
    go("c4_fetch", 4'd1);
    check("c4_retire", 16'(retire_cnt), 16'(RET_AFTER_4TH));

    // illegal state code 12
    force dut.state_q = state_t'(4'd12);
    step();
    release dut.state_q;
    step();
    check("ill_state", 16'(state), 16'd15);
    check("ill_err_code", 16'(err_code), 16'd1);
    check("ill_err", 16'(err), 16'd1);
    err_clear = 1'b1;
    go("ill_clear_fetch", 4'd1);
    err_clear = 1'b0;
    check("ill_clear_code", 16'(err_code), 16'd0);
    check("ill_clear_retire", 16'(retire_cnt), 16'(RET_AFTER_4TH));

    // one more ADD; err_clear outside ERROR has no effect
    C_Control = 6'b000000; complete = 1'b1; err_clear = 1'b1;
    go("add2_decode", 4'd2);
    go("add2_execute", 4'd3);
    err_clear = 1'b0;
    go("add2_update_rf", 4'd9);
    go("add2_update_pc", 4'd10);
    go("add2_fetch", 4'd1);
    check("wrap_retire", 16'(retire_cnt), 16'(RET_FINAL));

    // CALC_PC routes
    C_Control = 6'b011000;
    go("jsr_decode", 4'd2);
    go("jsr_calc_pc", 4'd4);
    go("jsr_update_rf", 4'd9);
    go("jsr_update_pc", 4'd10);
    go("jsr_fetch", 4'd1);
    C_Control = 6'b010000;
    go("br_decode", 4'd2);
    go("br_calc_pc", 4'd4);
    go("br_update_pc", 4'd10);
    go("br_fetch", 4'd1);

    // reset in the middle of a WRITE_MEM wait
    C_Control = 6'b100100;
    go("rw_decode", 4'd2);
    go("rw_calc_addr", 4'd5);
    go("rw_write_mem", 4'd8);
    mem_wait("rw", 4'd8, 2);
    complete = 1'b0;
    reset = 1'b1;
    go("rw_reset_fetch", 4'd1);
    reset = 1'b0;
    check("rw_reset_retire", 16'(retire_cnt), 16'd0);
    check("rw_reset_we", 16'(mem_we), 16'd0);
    check("rw_reset_err_code", 16'(err_code), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
